// File: rtl/data_sram_slave.sv
// Data SRAM slave: byte-strobed word array behind a fixed-latency,
// in-order response queue with addr_ok / data_ok handshakes.
module data_sram_slave #(
  parameter int ADDR_WD = 10,
  parameter int LATENCY = 2,
  parameter int DEPTH   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [2:0] CD_INIT = 3'(LATENCY - 1);

  logic [31:0] mem [2**ADDR_WD];

  logic [DEPTH-1:0] vld_q, vld_d;
  logic [31:0]      dat_q [DEPTH];
  logic [31:0]      dat_d [DEPTH];
  logic             wr_q  [DEPTH];
  logic             wr_d  [DEPTH];
  logic [2:0]       cd_q  [DEPTH];
  logic [2:0]       cd_d  [DEPTH];
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [ADDR_WD-1:0] idx;
  logic               accept;
  logic               pop;
  logic               unused;

  assign unused = ^{data_sram_size, data_sram_addr[1:0],
                    data_sram_addr[31:ADDR_WD+2]};

  assign idx    = data_sram_addr[ADDR_WD+1:2];
  assign data_sram_addr_ok = data_sram_req && (cnt_q < CW'(DEPTH));
  assign accept = data_sram_req && data_sram_addr_ok;
  assign pop    = vld_q[rptr_q] && (cd_q[rptr_q] == 3'd0);

  assign data_sram_data_ok = pop;
  assign data_sram_rdata   = (pop && !wr_q[rptr_q]) ? dat_q[rptr_q] : 32'h0;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    vld_d  = vld_q;
    dat_d  = dat_q;
    wr_d   = wr_q;
    cd_d   = cd_q;
    rptr_d = rptr_q;
    wptr_d = wptr_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i] && cd_q[i] != 3'd0) cd_d[i] = cd_q[i] - 3'd1;
    end
    if (pop) begin
      vld_d[rptr_q] = 1'b0;
      rptr_d        = nxt(rptr_q);
    end
    // The array is read before this edge's store, but only one request
    // per cycle exists, so a load always sees every earlier store.
    if (accept) begin
      vld_d[wptr_q] = 1'b1;
      dat_d[wptr_q] = data_sram_wr ? 32'h0 : mem[idx];
      wr_d[wptr_q]  = data_sram_wr;
      cd_d[wptr_q]  = CD_INIT;
      wptr_d        = nxt(wptr_q);
    end
    case ({accept, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q  <= '0;
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dat_q[i] <= '0;
        wr_q[i]  <= 1'b0;
        cd_q[i]  <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      dat_q  <= dat_d;
      wr_q   <= wr_d;
      cd_q   <= cd_d;
      rptr_q <= rptr_d;
      wptr_q <= wptr_d;
      cnt_q  <= cnt_d;
    end
  end

  // Backing array is deliberately never reset.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (data_sram_wstrb[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_sram_slave.sv
// Bench for data_sram_slave: two instances (LATENCY 2/DEPTH 2 and
// LATENCY 1/DEPTH 4) share stimulus and are checked against a queue model.
module tb_data_sram_slave;

  typedef struct {
    int          due;
    logic [31:0] d;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  strb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        aok [2];
  logic        dok [2];
  logic [31:0] rd  [2];

  int LAT [2] = '{2, 1};
  int DEP [2] = '{2, 4};

  logic [31:0] mem_m [2][1024];
  rsp_t        q0 [$];
  rsp_t        q1 [$];
  int          cyc;
  int          ncmp;
  int          nfail;
  logic [31:0] last_rd [2];
  int          run1;
  int          maxrun1;

  always #5 clk = ~clk;

  data_sram_slave #(.ADDR_WD(10), .LATENCY(2), .DEPTH(2)) u0 (
    .clk(clk), .reset(rst), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(strb),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_addr_ok(aok[0]), .data_sram_data_ok(dok[0]),
    .data_sram_rdata(rd[0])
  );

  data_sram_slave #(.ADDR_WD(10), .LATENCY(1), .DEPTH(4)) u1 (
    .clk(clk), .reset(rst), .data_sram_req(req), .data_sram_wr(wr),
    .data_sram_size(size), .data_sram_wstrb(strb),
    .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_addr_ok(aok[1]), .data_sram_data_ok(dok[1]),
    .data_sram_rdata(rd[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic [3:0] s,
                      input logic [31:0] a, input logic [31:0] wd);
    logic        acc  [2];
    logic        edok [2];
    logic [31:0] erd  [2];
    int          wi;
    req = r; wr = w; strb = s; addr = a; wdata = wd;
    size = 2'($urandom_range(0, 2));
    wi = int'(a[11:2]);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int   n;
      logic eok;
      rsp_t h;
      n = (k == 0) ? q0.size() : q1.size();
      eok = r && (rst || n < DEP[k]);
      edok[k] = 1'b0;
      erd[k]  = 32'h0;
      if (!rst && n > 0) begin
        h = (k == 0) ? q0[0] : q1[0];
        if (h.due == cyc) begin
          edok[k] = 1'b1;
          erd[k]  = h.d;
        end
      end
      chk($sformatf("u%0d.addr_ok", k), 32'(aok[k]), 32'(eok));
      chk($sformatf("u%0d.data_ok", k), 32'(dok[k]), 32'(edok[k]));
      chk($sformatf("u%0d.rdata", k), rd[k], erd[k]);
      if (dok[k]) last_rd[k] = rd[k];
      acc[k] = eok && !rst;
    end
    if (dok[1]) begin
      run1++;
      if (run1 > maxrun1) maxrun1 = run1;
    end else begin
      run1 = 0;
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      rsp_t e;
      if (rst) begin
        if (k == 0) q0.delete(); else q1.delete();
      end else begin
        if (edok[k]) begin
          if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        end
        if (acc[k]) begin
          e.due = cyc + LAT[k];
          e.d   = w ? 32'h0 : mem_m[k][wi];
          if (k == 0) q0.push_back(e); else q1.push_back(e);
          if (w) begin
            for (int b = 0; b < 4; b++)
              if (s[b]) mem_m[k][wi][8*b +: 8] = wd[8*b +: 8];
          end
        end
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  task automatic st(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] s);
    step(1'b1, 1'b1, s, a, d);
    idle(2);
  endtask

  task automatic ld(input logic [31:0] a);
    step(1'b1, 1'b0, 4'h0, a, 32'h0);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = ($urandom & 32'hFFFF_F000) | (32'($urandom_range(0, 15)) << 2)
        | 32'($urandom_range(0, 3));
    return a;
  endfunction

  initial begin
    ncmp = 0; nfail = 0; cyc = 0; run1 = 0; maxrun1 = 0;
    last_rd[0] = '0; last_rd[1] = '0;
    rst = 1'b1; req = 1'b0; wr = 1'b0; size = 2'd0;
    strb = 4'h0; addr = '0; wdata = '0;
    #1;
    idle(2);
    step(1'b1, 1'b0, 4'h0, 32'h40, 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 16; i++) st(32'(i * 4), $urandom, 4'hF);

    st(32'h100, 32'hDEAD_BEEF, 4'hF);
    ld(32'h100);
    idle(3);
    chk("store_load", last_rd[0], 32'hDEAD_BEEF);

    st(32'h104, 32'h1122_3344, 4'hF);
    st(32'h104, 32'hAAAA_AAAA, 4'b0100);
    ld(32'h105);
    idle(3);
    chk("byte_strobe", last_rd[0], 32'h11AA_3344);

    ld(32'h0000_1000);
    idle(3);
    chk("wrap", last_rd[0], mem_m[0][0]);

    for (int i = 0; i < 6; i++) ld(rnd_addr());
    idle(3);

    maxrun1 = 0;
    for (int i = 0; i < 4; i++) ld(rnd_addr());
    idle(3);
    chk("lat1_back_to_back", 32'(maxrun1), 32'd4);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 7)
        step(1'b1, 1'($urandom), 4'($urandom), rnd_addr(), $urandom);
      else
        idle(1);
    end
    idle(3);

    ld(rnd_addr());
    ld(rnd_addr());
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(4);
    ld(rnd_addr());
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
